uart_mem_bridge: RTL and testbench
==================================

Name: uart_mem_bridge

Overview:
- Sits between the UART byte receiver/transmitter and port B of the 128-bit data memory (uart write-enable, port-B address, uart data in/out).
- Load mode: packs incoming UART bytes into 128-bit words and writes them to memory.
- Dump mode: reads memory words and serialises them back out as bytes.
- Lets the host preload operands and retrieve results while the processor uses port A.

Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 128, memory word width; must be a multiple of 8.
- RD_LAT, 2, cycles from mem_addr presented to mem_rdata valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_load  in  1  one-cycle pulse; begin load.
- start_dump  in  1  one-cycle pulse; begin dump.
- base_addr  in  ADDR_W  first word address, sampled on start.
- word_count  in  ADDR_W  number of words, sampled on start.
- rx_valid  in  1  rx_data valid this cycle (single-cycle strobe, no backpressure).
- rx_data  in  8  received byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready.
- mem_addr  out  ADDR_W  port-B address.
- mem_wdata  out  DATA_W  port-B write data.
- mem_we  out  1  port-B write enable (uart_en).
- mem_rdata  in  DATA_W  port-B read data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at operation end.
- words_done  out  ADDR_W  words written or sent in current/last operation.
- rx_drop  out  1  sticky: an rx byte arrived while not collecting; cleared on next start_load.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: tx_data, tx_valid, mem_addr, mem_wdata, mem_we, busy, done, words_done, rx_drop. Byte counter and shift register are cleared.
- States: IDLE, L_COLLECT, L_WRITE, D_READ, D_WAIT, D_SEND, FINISH.
- IDLE:
  - start_load -> latch base/count, words_done=0, rx_drop=0, go L_COLLECT.
  - start_dump -> latch, words_done=0, go D_READ.
  - Both asserted in the same cycle: load wins; dump is ignored.
  - word_count=0: go straight to FINISH; no memory access, no tx.
  - Start pulses while busy are ignored.
- L_COLLECT:
  - Each rx_valid places rx_data at bits [8*k+7:8*k], k=0..15. The first byte lands in [7:0] (little-endian).
  - After byte 15, go L_WRITE.
- L_WRITE (one cycle): mem_we=1, mem_addr=current address, mem_wdata=packed word. Then address+1, words_done+1. Go FINISH if words_done reaches count, else L_COLLECT.
  - rx_valid arriving during L_WRITE is accepted as byte 0 of the next word (not dropped).
- rx_valid in any state other than L_COLLECT/L_WRITE sets rx_drop; the byte is discarded.
- D_READ: drive mem_addr, mem_we=0, go D_WAIT. D_WAIT counts RD_LAT-1 cycles, then captures mem_rdata into the shift register and goes D_SEND.
- D_SEND:
  - tx_valid=1, tx_data = byte k, starting at [7:0].
  - k advances only on tx_valid & tx_ready; tx_data is stable while stalled.
  - After byte 15 is accepted: address+1, words_done+1, then D_READ or FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
- Address wraps modulo 2^ADDR_W (0xFFFF+1 -> 0x0000). words_done never wraps because it is bounded by word_count.
- mem_we is high only in L_WRITE; mem_wdata holds its last value otherwise.
- Reset mid-operation aborts immediately. A partial word is never written. No done pulse is produced.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 asynchronously; after release, busy=0 until a start pulse.
- Load 1 word: base=0x0010, count=1, bytes 0x00..0x0F -> a single mem_we pulse, addr 0x0010, wdata=0x0F0E..0100; done one cycle later; words_done=1.
- Load 2 words at base 0xFFFF with back-to-back rx_valid every cycle -> writes at 0xFFFF then 0x0000; no rx_drop; byte 16 (the one arriving during L_WRITE) lands in word 1 bits [7:0].
- Dump 1 word at 0x0020 (memory holds 0x...0123456789ABCDEF), tx_ready toggling 1/0 -> tx bytes EF,CD,AB,89,67,45,23,01,... with each byte held while stalled; done after byte 16.
- Simultaneous start_load+start_dump with count=0 -> no mem_we, no tx_valid, done pulse within 2 cycles; rx_valid sent during IDLE afterwards sets rx_drop=1.
- Reset asserted after 7 load bytes -> no mem_we ever; after release, a new load of 16 bytes writes a clean word containing no residue of the earlier bytes.

Source files
------------

// File: rtl/uart_mem_bridge.sv
`default_nettype none
//==============================================================================
// Module : uart_mem_bridge
// Packs UART bytes into memory words (load) or streams memory words out as bytes (dump).
// Rev    : 1.0
//==============================================================================
module uart_mem_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load_i,
    input  logic              start_dump_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] word_count_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] words_done_o,
    output logic              rx_drop_o
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(RD_LAT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_L_COLLECT = 3'd1;
    localparam logic [2:0] S_L_WRITE   = 3'd2;
    localparam logic [2:0] S_D_READ    = 3'd3;
    localparam logic [2:0] S_D_WAIT    = 3'd4;
    localparam logic [2:0] S_D_SEND    = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] words_done_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rx_drop_q;

    logic              w_last_byte;
    logic              w_last_word;
    logic              w_lat_done;
    logic              w_collecting;
    logic [DATA_W-1:0] w_shift_in;

    assign w_last_byte  = (byte_cnt_q == LAST_BYTE);
    assign w_last_word  = ((words_done_q + ADDR_W'(1)) == count_q);
    assign w_lat_done   = (lat_cnt_q == LAST_LAT);
    assign w_collecting = (state_q == S_L_COLLECT) || (state_q == S_L_WRITE);
    // Bytes enter at the top so that after a full word the first byte sits in [7:0].
    assign w_shift_in   = {rx_data_i, shreg_q[DATA_W-1:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_load_i) begin
                    state_d = (word_count_i == '0) ? S_FINISH : S_L_COLLECT;
                end else if (start_dump_i) begin
                    state_d = (word_count_i == '0) ? S_FINISH : S_D_READ;
                end
            end
            S_L_COLLECT: if (rx_valid_i && w_last_byte) state_d = S_L_WRITE;
            S_L_WRITE:   state_d = w_last_word ? S_FINISH : S_L_COLLECT;
            S_D_READ:    state_d = S_D_WAIT;
            S_D_WAIT:    if (w_lat_done) state_d = S_D_SEND;
            S_D_SEND: begin
                if (tx_ready_i && w_last_byte) begin
                    state_d = w_last_word ? S_FINISH : S_D_READ;
                end
            end
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_FINISH);
        mem_we_o   = (state_q == S_L_WRITE);
        tx_valid_o = (state_q == S_D_SEND);
    end

    assign tx_data_o    = shreg_q[7:0];
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign words_done_o = words_done_q;
    assign rx_drop_o    = rx_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            count_q      <= '0;
            words_done_q <= '0;
            byte_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            shreg_q      <= '0;
            wdata_q      <= '0;
            rx_drop_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_load_i || start_dump_i) begin
                        addr_q       <= base_addr_i;
                        count_q      <= word_count_i;
                        words_done_q <= '0;
                        byte_cnt_q   <= '0;
                    end
                    if (start_load_i) rx_drop_q <= 1'b0;
                end
                S_L_COLLECT: begin
                    if (rx_valid_i) begin
                        shreg_q    <= w_shift_in;
                        byte_cnt_q <= w_last_byte ? '0 : byte_cnt_q + BCNT_W'(1);
                        if (w_last_byte) wdata_q <= w_shift_in;
                    end
                end
                S_L_WRITE: begin
                    addr_q       <= addr_q + ADDR_W'(1);
                    words_done_q <= words_done_q + ADDR_W'(1);
                    // A byte arriving while writing starts the next word.
                    if (rx_valid_i) begin
                        shreg_q    <= w_shift_in;
                        byte_cnt_q <= BCNT_W'(1);
                    end
                end
                S_D_READ: lat_cnt_q <= '0;
                S_D_WAIT: begin
                    if (w_lat_done) begin
                        shreg_q    <= mem_rdata_i;
                        byte_cnt_q <= '0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                S_D_SEND: begin
                    if (tx_ready_i) begin
                        shreg_q <= shreg_q >> 8;
                        if (w_last_byte) begin
                            byte_cnt_q   <= '0;
                            addr_q       <= addr_q + ADDR_W'(1);
                            words_done_q <= words_done_q + ADDR_W'(1);
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            // A stray byte is flagged even when it coincides with a start pulse.
            if (rx_valid_i && !w_collecting) rx_drop_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
//==============================================================================
// Module : tb_uart_mem_bridge
// Directed self-checking bench for uart_mem_bridge with a 2-cycle read memory model.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
module tb_uart_mem_bridge;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_load = 1'b0;
    logic              start_dump = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] words_done;
    logic              rx_drop;

    always #5 clk = ~clk;

    uart_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load_i (start_load),
        .start_dump_i (start_dump),
        .base_addr_i  (base_addr),
        .word_count_i (word_count),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy),
        .done_o       (done),
        .words_done_o (words_done),
        .rx_drop_o    (rx_drop)
    );

    // Port-B read model: data appears two cycles after the address.
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] p1 = '0;
    logic [DATA_W-1:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= mem[mem_addr[7:0]];
        p2 <= p1;
    end
    assign mem_rdata = p2;

    int cyc = 0, we_cnt = 0, done_cnt = 0, txv_cnt = 0, stall_err = 0;
    int last_we_cyc = -1, last_done_cyc = -1, last_acc_cyc = -1;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    logic [7:0]        tx_q [$];

    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            last_we_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (tx_valid) txv_cnt <= txv_cnt + 1;
        if (stall_prev && (!tx_valid || tx_data !== stall_data)) stall_err <= stall_err + 1;
        if (tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
            last_acc_cyc <= cyc;
        end
        stall_prev <= tx_valid && !tx_ready;
        stall_data <= tx_data;
        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic ld, input logic dp, input logic [15:0] base,
                            input logic [15:0] cnt);
        @(negedge clk);
        start_load = ld;
        start_dump = dp;
        base_addr  = base;
        word_count = cnt;
        @(negedge clk);
        start_load = 1'b0;
        start_dump = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = first + 8'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk(tag, 128'(seen), 128'd1);
        @(negedge clk);
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({tx_data, tx_valid, mem_addr, mem_we, busy, done, words_done, rx_drop});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int we0, done0, txv0;
    logic [7:0] exp_b [16];

    initial begin
        exp_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
                  8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        for (int i = 0; i < 256; i++) mem[i] = {16{8'(i)}};
        mem[8'h20] = 128'hFEDCBA98_76543210_01234567_89ABCDEF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 128'd0);
        chk("reset_wdata", mem_wdata, 128'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);

        // Load one word
        we0 = we_cnt; done0 = done_cnt;
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(1'b1, 1'b0, 16'h0010, 16'd1);
        chk("load1_busy", 128'(busy), 128'd1);
        send_bytes(8'h00, 16);
        wait_done("load1_done", 20);
        chk("load1_we_cnt", 128'(we_cnt - we0), 128'd1);
        chk("load1_addr", 128'(wr_addr_q[0]), 128'h0010);
        chk("load1_wdata", wr_data_q[0], 128'h0F0E0D0C0B0A09080706050403020100);
        chk("load1_done_after_we", 128'(last_done_cyc - last_we_cyc), 128'd1);
        chk("load1_done_cnt", 128'(done_cnt - done0), 128'd1);
        chk("load1_words_done", 128'(words_done), 128'd1);
        chk("load1_busy_after", 128'({busy, done}), 128'd0);

        // Load two words across the address wrap, bytes back-to-back
        we0 = we_cnt;
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(1'b1, 1'b0, 16'hFFFF, 16'd2);
        send_bytes(8'h20, 32);
        wait_done("load2_done", 20);
        chk("load2_we_cnt", 128'(we_cnt - we0), 128'd2);
        chk("load2_addr0", 128'(wr_addr_q[0]), 128'hFFFF);
        chk("load2_addr1", 128'(wr_addr_q[1]), 128'h0000);
        chk("load2_wdata0", wr_data_q[0], 128'h2F2E2D2C2B2A29282726252423222120);
        chk("load2_wdata1", wr_data_q[1], 128'h3F3E3D3C3B3A39383736353433323130);
        chk("load2_rx_drop", 128'(rx_drop), 128'd0);
        chk("load2_words_done", 128'(words_done), 128'd2);

        // Dump one word with a toggling tx_ready
        we0 = we_cnt;
        tx_q.delete();
        do_start(1'b0, 1'b1, 16'h0020, 16'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
                tx_ready = ~tx_ready;
            end
            tx_ready = 1'b0;
            chk("dump_done", 128'(seen), 128'd1);
            @(negedge clk);
        end
        chk("dump_tx_cnt", 128'(tx_q.size()), 128'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("dump_byte%0d", i), 128'(tx_q[i]), 128'(exp_b[i]));
        chk("dump_stall_stable", 128'(stall_err), 128'd0);
        chk("dump_no_we", 128'(we_cnt - we0), 128'd0);
        chk("dump_words_done", 128'(words_done), 128'd1);
        chk("dump_done_after_last", 128'(last_done_cyc - last_acc_cyc), 128'd1);
        chk("dump_busy_after", 128'(busy), 128'd0);

        // Stray byte while idle, then simultaneous starts with count 0
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk); rx_valid = 1'b0;
        chk("idle_rx_drop_set", 128'(rx_drop), 128'd1);
        we0 = we_cnt; txv0 = txv_cnt;
        do_start(1'b1, 1'b1, 16'h0030, 16'd0);
        wait_done("zero_done", 2);
        chk("zero_no_we", 128'(we_cnt - we0), 128'd0);
        chk("zero_no_tx", 128'(txv_cnt - txv0), 128'd0);
        chk("zero_load_wins", 128'(rx_drop), 128'd0);
        chk("zero_words_done", 128'(words_done), 128'd0);
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'hAA;
        @(negedge clk); rx_valid = 1'b0;
        chk("zero_rx_drop_after", 128'(rx_drop), 128'd1);

        // Reset in the middle of a load
        we0 = we_cnt; done0 = done_cnt;
        do_start(1'b1, 1'b0, 16'h0040, 16'd1);
        send_bytes(8'hE0, 7);
        chk("abort_busy_before", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async_outputs", out_vec(), 128'd0);
        chk("abort_async_wdata", mem_wdata, 128'd0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy_after", 128'(busy), 128'd0);
        chk("abort_no_we", 128'(we_cnt - we0), 128'd0);
        chk("abort_no_done", 128'(done_cnt - done0), 128'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        do_start(1'b1, 1'b0, 16'h0050, 16'd1);
        send_bytes(8'h80, 16);
        wait_done("clean_done", 20);
        chk("clean_we_cnt", 128'(we_cnt - we0), 128'd1);
        chk("clean_addr", 128'(wr_addr_q[0]), 128'h0050);
        chk("clean_wdata", wr_data_q[0], 128'h8F8E8D8C8B8A89888786858483828180);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
